// File: rtl/writeback_unit.sv
// Writeback stage for the IXU1/IXU2/LSU lanes.
// Registers each EX result into its WB lane, turns invalid, x0 and
// same-bundle WAW-losing lanes into bubbles, and holds the pipeline
// (o_stall) while a load waits for memory, with a sticky timeout flag.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_ixu1_ex_* / i_ixu2_ex_*       integer lane valid, rd, result
//   i_lsu_ex_*                      LSU valid, rd, result, is_load
//   i_mem_rvalid, i_mem_rdata       load data return
//   o_ixu1_wb_* / o_ixu2_wb_*       registered WB rd and data
//   o_lsu_wb_*                      registered LSU WB rd, data, is_load
//   o_rf_we                         register-file write enables {lsu, ixu2, ixu1}
//   o_stall                         high while a load is outstanding
//   o_load_timeout                  sticky: a load was abandoned
module writeback_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ixu1_ex_valid,
    input  logic [4:0]  i_ixu1_ex_rd,
    input  logic [31:0] i_ixu1_ex_result,
    input  logic        i_ixu2_ex_valid,
    input  logic [4:0]  i_ixu2_ex_rd,
    input  logic [31:0] i_ixu2_ex_result,
    input  logic        i_lsu_ex_valid,
    input  logic [4:0]  i_lsu_ex_rd,
    input  logic [31:0] i_lsu_ex_result,
    input  logic        i_lsu_ex_is_load,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [4:0]  o_ixu1_wb_rd,
    output logic [31:0] o_ixu1_wb_data,
    output logic [4:0]  o_ixu2_wb_rd,
    output logic [31:0] o_ixu2_wb_data,
    output logic [4:0]  o_lsu_wb_rd,
    output logic [31:0] o_lsu_wb_data,
    output logic        o_lsu_wb_is_load,
    output logic [2:0]  o_rf_we,
    output logic        o_stall,
    output logic        o_load_timeout
);

    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_saved_rd;
    logic [RW-1:0]   r_ixu1_rd, r_ixu2_rd, r_lsu_rd;
    logic [DW-1:0]   r_ixu1_data, r_ixu2_data, r_lsu_data;
    logic            r_lsu_is_load;
    logic            r_stall;
    logic            r_timeout;

    state_t          w_nxt_state;
    logic [CW-1:0]   w_nxt_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [RW-1:0]   w_nxt_saved_rd;
    logic [RW-1:0]   w_nxt_ixu1_rd, w_nxt_ixu2_rd, w_nxt_lsu_rd;
    logic [DW-1:0]   w_nxt_ixu1_data, w_nxt_ixu2_data, w_nxt_lsu_data;
    logic            w_nxt_lsu_is_load;
    logic            w_nxt_timeout;
    logic            w_ixu1_wr, w_ixu2_wr;
    logic [RW-1:0]   w_lsu_rd_eff;

    // Same-bundle WAW resolution: ixu1 beats ixu2 beats lsu; x0 never writes.
    always_comb begin
        w_ixu1_wr = i_ixu1_ex_valid && (i_ixu1_ex_rd != '0);
        w_ixu2_wr = i_ixu2_ex_valid && (i_ixu2_ex_rd != '0)
                    && !(w_ixu1_wr && (i_ixu1_ex_rd == i_ixu2_ex_rd));
        w_lsu_rd_eff = '0;
        if (i_lsu_ex_valid && (i_lsu_ex_rd != '0)
            && !(w_ixu1_wr && (i_ixu1_ex_rd == i_lsu_ex_rd))
            && !(w_ixu2_wr && (i_ixu2_ex_rd == i_lsu_ex_rd))) begin
            w_lsu_rd_eff = i_lsu_ex_rd;
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    // Next-state and next-output logic; every lane defaults to a bubble.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_cnt         = r_cnt;
        w_nxt_saved_rd    = r_saved_rd;
        w_nxt_timeout     = r_timeout;
        w_nxt_ixu1_rd     = '0;
        w_nxt_ixu1_data   = '0;
        w_nxt_ixu2_rd     = '0;
        w_nxt_ixu2_data   = '0;
        w_nxt_lsu_rd      = '0;
        w_nxt_lsu_data    = '0;
        w_nxt_lsu_is_load = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ixu1_wr) begin
                    w_nxt_ixu1_rd   = i_ixu1_ex_rd;
                    w_nxt_ixu1_data = i_ixu1_ex_result;
                end
                if (w_ixu2_wr) begin
                    w_nxt_ixu2_rd   = i_ixu2_ex_rd;
                    w_nxt_ixu2_data = i_ixu2_ex_result;
                end
                if (i_lsu_ex_valid && i_lsu_ex_is_load) begin
                    // A load that lost WAW is still waited for but writes nothing.
                    w_nxt_saved_rd = w_lsu_rd_eff;
                    w_nxt_cnt      = '0;
                    w_nxt_state    = ST_WAIT_MEM;
                end else if (w_lsu_rd_eff != '0) begin
                    w_nxt_lsu_rd   = w_lsu_rd_eff;
                    w_nxt_lsu_data = i_lsu_ex_result;
                end
            end
            ST_WAIT_MEM: begin
                if (i_mem_rvalid) begin
                    // Data beats a same-cycle timeout.
                    w_nxt_lsu_rd      = r_saved_rd;
                    w_nxt_lsu_data    = (r_saved_rd != '0) ? i_mem_rdata : '0;
                    w_nxt_lsu_is_load = 1'b1;
                    w_nxt_state       = ST_IDLE;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_nxt_cnt     = w_cnt_inc;
                    w_nxt_timeout = 1'b1;
                    w_nxt_state   = ST_IDLE;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_saved_rd    <= '0;
            r_ixu1_rd     <= '0;
            r_ixu1_data   <= '0;
            r_ixu2_rd     <= '0;
            r_ixu2_data   <= '0;
            r_lsu_rd      <= '0;
            r_lsu_data    <= '0;
            r_lsu_is_load <= 1'b0;
            r_stall       <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_saved_rd    <= w_nxt_saved_rd;
            r_ixu1_rd     <= w_nxt_ixu1_rd;
            r_ixu1_data   <= w_nxt_ixu1_data;
            r_ixu2_rd     <= w_nxt_ixu2_rd;
            r_ixu2_data   <= w_nxt_ixu2_data;
            r_lsu_rd      <= w_nxt_lsu_rd;
            r_lsu_data    <= w_nxt_lsu_data;
            r_lsu_is_load <= w_nxt_lsu_is_load;
            r_stall       <= (w_nxt_state == ST_WAIT_MEM);
            r_timeout     <= w_nxt_timeout;
        end
    end

    assign o_ixu1_wb_rd     = r_ixu1_rd;
    assign o_ixu1_wb_data   = r_ixu1_data;
    assign o_ixu2_wb_rd     = r_ixu2_rd;
    assign o_ixu2_wb_data   = r_ixu2_data;
    assign o_lsu_wb_rd      = r_lsu_rd;
    assign o_lsu_wb_data    = r_lsu_data;
    assign o_lsu_wb_is_load = r_lsu_is_load;
    assign o_rf_we          = {r_lsu_rd != '0, r_ixu2_rd != '0, r_ixu1_rd != '0};
    assign o_stall          = r_stall;
    assign o_load_timeout   = r_timeout;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit (TIMEOUT=4): directed scenarios
// against fixed values, then random traffic against a behavioural model.
module tb_writeback_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ixu1_v, ixu2_v, lsu_v, lsu_ld, mem_rv;
    logic [4:0]  ixu1_rd, ixu2_rd, lsu_rd;
    logic [31:0] ixu1_res, ixu2_res, lsu_res, mem_rd;
    logic [4:0]  wb1_rd, wb2_rd, wbl_rd;
    logic [31:0] wb1_d, wb2_d, wbl_d;
    logic        wbl_ld, stall, ltimeout;
    logic [2:0]  rf_we;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: waiting for load data, cycles waited, target rd, sticky error.
    bit          m_wait;
    int          m_cnt;
    logic [4:0]  m_rd;
    bit          m_to;
    logic [116:0] exp_all;
    logic [116:0] obs_all;

    always #5 clk = ~clk;

    writeback_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ixu1_ex_valid(ixu1_v), .i_ixu1_ex_rd(ixu1_rd), .i_ixu1_ex_result(ixu1_res),
        .i_ixu2_ex_valid(ixu2_v), .i_ixu2_ex_rd(ixu2_rd), .i_ixu2_ex_result(ixu2_res),
        .i_lsu_ex_valid(lsu_v), .i_lsu_ex_rd(lsu_rd), .i_lsu_ex_result(lsu_res),
        .i_lsu_ex_is_load(lsu_ld),
        .i_mem_rvalid(mem_rv), .i_mem_rdata(mem_rd),
        .o_ixu1_wb_rd(wb1_rd), .o_ixu1_wb_data(wb1_d),
        .o_ixu2_wb_rd(wb2_rd), .o_ixu2_wb_data(wb2_d),
        .o_lsu_wb_rd(wbl_rd), .o_lsu_wb_data(wbl_d), .o_lsu_wb_is_load(wbl_ld),
        .o_rf_we(rf_we), .o_stall(stall), .o_load_timeout(ltimeout)
    );

    assign obs_all = {wb1_rd, wb1_d, wb2_rd, wb2_d, wbl_rd, wbl_d, wbl_ld, rf_we, stall, ltimeout};

    // Expected result of the coming clock edge, from the writeback rules.
    task automatic model_edge();
        logic [4:0]  r1, r2, rl, tgt;
        logic [31:0] d1, d2, dl;
        logic        il;
        r1 = '0; r2 = '0; rl = '0; d1 = '0; d2 = '0; dl = '0; il = 1'b0;
        if (!rst_n) begin
            m_wait = 0; m_cnt = 0; m_rd = '0; m_to = 0;
        end else if (!m_wait) begin
            if (ixu1_v && ixu1_rd != 0) begin r1 = ixu1_rd; d1 = ixu1_res; end
            if (ixu2_v && ixu2_rd != 0 && ixu2_rd != r1) begin r2 = ixu2_rd; d2 = ixu2_res; end
            tgt = (lsu_v && lsu_rd != 0 && lsu_rd != r1 && lsu_rd != r2) ? lsu_rd : 5'd0;
            if (lsu_v && lsu_ld) begin
                m_wait = 1; m_cnt = 0; m_rd = tgt;
            end else if (tgt != 0) begin
                rl = tgt; dl = lsu_res;
            end
        end else begin
            if (mem_rv) begin
                rl = m_rd; dl = (m_rd != 0) ? mem_rd : 32'd0; il = 1'b1; m_wait = 0;
            end else begin
                m_cnt++;
                if (m_cnt == int'(TO)) begin m_to = 1; m_wait = 0; end
            end
        end
        exp_all = {r1, d1, r2, d2, rl, dl, il, rl != 0, r2 != 0, r1 != 0, m_wait, m_to};
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ixu1_v = 0; ixu1_rd = 0; ixu1_res = 0;
        ixu2_v = 0; ixu2_rd = 0; ixu2_res = 0;
        lsu_v = 0; lsu_rd = 0; lsu_res = 0; lsu_ld = 0;
        mem_rv = 0; mem_rd = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ixu1_v = 1; ixu1_rd = 5'd3; ixu1_res = 32'h1234;
        rst_n = 0;
        tick(); tick();
        if (obs_all !== 117'd0) begin
            n_errors++; $display("FAIL reset_outputs got=%h want=0", obs_all);
        end
        n_checks++;
        rst_n = 1;
        clear_inputs();
        tick();
    endtask

    task automatic test_ixu_lanes();
        // Two distinct destinations.
        clear_inputs();
        ixu1_v = 1; ixu1_rd = 5'd5; ixu1_res = 32'hA;
        ixu2_v = 1; ixu2_rd = 5'd6; ixu2_res = 32'hB;
        tick();
        if ({wb1_rd, wb1_d, wb2_rd, wb2_d, rf_we} !== {5'd5, 32'hA, 5'd6, 32'hB, 3'b011}) begin
            n_errors++; $display("FAIL two_lanes got=%h/%h %h/%h we=%b want=5/a 6/b we=011",
                                 wb1_rd, wb1_d, wb2_rd, wb2_d, rf_we);
        end
        n_checks++;
        // Same-bundle WAW: ixu1 wins.
        ixu1_rd = 5'd9; ixu1_res = 32'd1;
        ixu2_rd = 5'd9; ixu2_res = 32'd2;
        tick();
        if ({wb1_rd, wb1_d, wb2_rd, wb2_d, rf_we} !== {5'd9, 32'd1, 5'd0, 32'd0, 3'b001}) begin
            n_errors++; $display("FAIL waw got=%h/%h %h/%h we=%b want=9/1 0/0 we=001",
                                 wb1_rd, wb1_d, wb2_rd, wb2_d, rf_we);
        end
        n_checks++;
        // x0 destinations on all lanes become bubbles.
        ixu1_rd = 0; ixu1_res = 32'hFFFF_FFFF;
        ixu2_rd = 0; ixu2_res = 32'h5555_5555;
        lsu_v = 1; lsu_rd = 0; lsu_res = 32'h7777_7777;
        tick();
        if (obs_all !== 117'd0) begin
            n_errors++; $display("FAIL x0_bubbles got=%h want=0", obs_all);
        end
        n_checks++;
        // Non-load LSU op writes its result.
        clear_inputs();
        lsu_v = 1; lsu_rd = 5'd12; lsu_res = 32'hCAFE_0001;
        tick();
        if ({wbl_rd, wbl_d, wbl_ld, rf_we} !== {5'd12, 32'hCAFE_0001, 1'b0, 3'b100}) begin
            n_errors++; $display("FAIL lsu_alu got=%h/%h ld=%b we=%b want=c/cafe0001 ld=0 we=100",
                                 wbl_rd, wbl_d, wbl_ld, rf_we);
        end
        n_checks++;
        clear_inputs();
        tick();
    endtask

    task automatic test_load();
        int stall_cycles;
        clear_inputs();
        ixu1_v = 1; ixu1_rd = 5'd4; ixu1_res = 32'h44;
        lsu_v = 1; lsu_rd = 5'd7; lsu_ld = 1;
        tick();
        if ({wb1_rd, wb1_d, wbl_rd, wbl_ld, rf_we} !== {5'd4, 32'h44, 5'd0, 1'b0, 3'b001}) begin
            n_errors++; $display("FAIL load_capture got=%h/%h lsu=%h ld=%b we=%b want=4/44 lsu=0 ld=0 we=001",
                                 wb1_rd, wb1_d, wbl_rd, wbl_ld, rf_we);
        end
        n_checks++;
        stall_cycles = stall ? 1 : 0;
        ixu1_rd = 5'd8;  // held bundle; must not be written while waiting
        tick(); stall_cycles += stall ? 1 : 0;
        if ({wb1_rd, rf_we} !== {5'd0, 3'b000}) begin
            n_errors++; $display("FAIL wait_bubbles got=%h we=%b want=0 we=000", wb1_rd, rf_we);
        end
        n_checks++;
        tick(); stall_cycles += stall ? 1 : 0;
        mem_rv = 1; mem_rd = 32'hDEAD_BEEF;
        tick();
        if (stall_cycles != 3 || stall !== 1'b0) begin
            n_errors++; $display("FAIL load_stall got=%0d cycles stall=%b want=3 cycles stall=0",
                                 stall_cycles, stall);
        end
        n_checks++;
        if ({wbl_rd, wbl_d, wbl_ld, rf_we} !== {5'd7, 32'hDEAD_BEEF, 1'b1, 3'b100}) begin
            n_errors++; $display("FAIL load_return got=%h/%h ld=%b we=%b want=7/deadbeef ld=1 we=100",
                                 wbl_rd, wbl_d, wbl_ld, rf_we);
        end
        n_checks++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout_race();
        // Data arrives in the last allowed cycle: data wins, no error.
        clear_inputs();
        lsu_v = 1; lsu_rd = 5'd11; lsu_ld = 1;
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        mem_rv = 1; mem_rd = 32'h0BAD_F00D;
        tick();
        if ({wbl_rd, wbl_d, wbl_ld, stall, ltimeout} !== {5'd11, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL race_data_wins got=%h/%h ld=%b st=%b to=%b want=b/0badf00d ld=1 st=0 to=0",
                                 wbl_rd, wbl_d, wbl_ld, stall, ltimeout);
        end
        n_checks++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int stall_cycles;
        clear_inputs();
        lsu_v = 1; lsu_rd = 5'd13; lsu_ld = 1;
        stall_cycles = 0;
        for (int i = 0; i < int'(TO) + 1; i++) begin
            tick();
            stall_cycles += stall ? 1 : 0;
        end
        if (stall_cycles != int'(TO) || ltimeout !== 1'b1 || stall !== 1'b0 || rf_we !== 3'b000) begin
            n_errors++; $display("FAIL timeout got=%0d stall cycles to=%b st=%b we=%b want=%0d to=1 st=0 we=000",
                                 stall_cycles, ltimeout, stall, rf_we, TO);
        end
        n_checks++;
        clear_inputs();
        mem_rv = 1; mem_rd = 32'h1111_2222;
        tick();
        if ({rf_we, wbl_rd, wbl_ld, ltimeout} !== {3'b000, 5'd0, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL late_rvalid got=we %b rd %h ld %b to %b want=we 000 rd 0 ld 0 to 1",
                                 rf_we, wbl_rd, wbl_ld, ltimeout);
        end
        n_checks++;
        clear_inputs();
        tick();
        if (ltimeout !== 1'b1) begin
            n_errors++; $display("FAIL timeout_sticky got=%b want=1", ltimeout);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        lsu_v = 1; lsu_rd = 5'd20; lsu_ld = 1;
        tick(); tick();
        clear_inputs();
        rst_n = 0;
        tick();
        if ({stall, ltimeout} !== 2'b00) begin
            n_errors++; $display("FAIL reset_mid_wait got=st %b to %b want=st 0 to 0", stall, ltimeout);
        end
        n_checks++;
        rst_n = 1;
        mem_rv = 1; mem_rd = 32'h3333_4444;
        tick();
        if ({rf_we, wbl_ld, stall} !== {3'b000, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL abandoned_load got=we %b ld %b st %b want=we 000 ld 0 st 0",
                                 rf_we, wbl_ld, stall);
        end
        n_checks++;
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        // Small rd range forces WAW collisions; occasional reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            ixu1_v   = 1'($urandom_range(0, 1));
            ixu1_rd  = 5'($urandom_range(0, 3));
            ixu1_res = $urandom;
            ixu2_v   = 1'($urandom_range(0, 1));
            ixu2_rd  = 5'($urandom_range(0, 3));
            ixu2_res = $urandom;
            lsu_v    = 1'($urandom_range(0, 1));
            lsu_rd   = 5'($urandom_range(0, 3));
            lsu_res  = $urandom;
            lsu_ld   = 1'($urandom_range(0, 1));
            mem_rv   = ($urandom_range(0, 3) == 0);
            mem_rd   = $urandom;
            tick();
            if (obs_all !== exp_all) begin
                n_errors++; $display("FAIL random[%0d] got=%h want=%h", i, obs_all, exp_all);
            end
            n_checks++;
        end
        rst_n = 1;
        clear_inputs();
    endtask

    initial begin
        m_wait = 0; m_cnt = 0; m_rd = '0; m_to = 0; exp_all = '0;
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_ixu_lanes();
        test_load();
        test_timeout_race();
        test_reset_mid_wait();
        test_timeout();
        rst_n = 0; tick(); rst_n = 1; tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 TIMEOUT, 255, maximum cycles spent in WAIT_MEM before a load is abandoned (range 1..255, 8-bit counter).
REQ-002 One clock; reset is synchronous and active-low (ports clk, rst_n; this polarity and synchronicity are fixed).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 ixu1_ex_valid  in  1  IXU1 result valid in EX.
REQ-006 ixu1_ex_rd  in  5  IXU1 destination register.
REQ-007 ixu1_ex_result  in  32  IXU1 result.
REQ-008 ixu2_ex_valid  in  1  IXU2 result valid in EX.
REQ-009 ixu2_ex_rd  in  5  IXU2 destination register.
REQ-010 ixu2_ex_result  in  32  IXU2 result.
REQ-011 lsu_ex_valid  in  1  LSU op valid in EX; stores arrive with rd=0.
REQ-012 lsu_ex_rd  in  5  LSU destination register.
REQ-013 lsu_ex_result  in  32  LSU non-load result.
REQ-014 lsu_ex_is_load  in  1  LSU op is a load.
REQ-015 mem_rvalid  in  1  load data return strobe.
REQ-016 mem_rdata  in  32  load return data.
REQ-017 ixu1_wb_rd / ixu2_wb_rd / lsu_wb_rd  out  5 each  registered WB destinations, feeding the forwarding unit and register file.
REQ-018 ixu1_wb_data / ixu2_wb_data / lsu_wb_data  out  32 each  registered WB data.
REQ-019 lsu_wb_is_load  out  1  lsu_wb lane holds load data.
REQ-020 rf_we  out  3  register-file write enables {lsu, ixu2, ixu1}.
REQ-021 stall  out  1  holds upstream EX bundle while a load is outstanding.
REQ-022 load_timeout  out  1  sticky error flag; cleared only by reset.

Function
REQ-023 FSM states: IDLE and WAIT_MEM. stall = (state==WAIT_MEM), driven registered.
REQ-024 Bubble definition: rd=0, data=0, rf_we bit=0.
- Any lane whose rd==0 or whose valid==0 shall be written as a bubble, so a forwarded x0 always reads 0.
REQ-025 IDLE, stall=0: each cycle all three lanes are captured into the WB registers with 1-cycle latency.
- rf_we bit = 1 iff the captured rd != 0.
REQ-026 IDLE, lsu_ex_valid=1 and lsu_ex_is_load=1:
- Capture the load rd in an internal register.
- LSU lane becomes a bubble next cycle with lsu_wb_is_load=0.
- Next state WAIT_MEM; the timeout counter is cleared.
- IXU lanes of the same bundle are written normally.
REQ-027 WAIT_MEM behaviour:
- IXU lanes output bubbles every cycle.
- EX inputs are ignored, since upstream holds them.
REQ-028 WAIT_MEM exit on data: when mem_rvalid=1, the next cycle shall show:
- lsu_wb_rd = saved rd, lsu_wb_data = mem_rdata, lsu_wb_is_load=1, rf_we[2]=(saved rd != 0).
- State returns to IDLE; stall=0.
REQ-029 mem_rvalid in IDLE shall be ignored.
REQ-030 WAIT_MEM timeout: counter increments each cycle without mem_rvalid. Upon reaching TIMEOUT:
- Set load_timeout.
- Return to IDLE; the LSU lane is a bubble.
- If mem_rvalid arrives in the same cycle the count hits TIMEOUT, the data wins: writeback proceeds and no error is flagged.
REQ-031 WAW within one bundle: ixu1 > ixu2 > lsu, matching forwarding priority.
- A lower-priority lane with the same nonzero rd as a higher-priority valid lane is written as a bubble.
- A load's rd is compared only at load capture.
REQ-032 Non-load LSU ops shall write lsu_ex_result with lsu_wb_is_load=0.

Reset
REQ-033 While rst_n=0 at a clock edge, the following shall all be 0, and the state shall be IDLE:
- all wb_rd, all wb_data, lsu_wb_is_load, rf_we, stall, load_timeout, the timeout counter, the saved rd.
REQ-034 A reset during WAIT_MEM shall abandon the load; a later mem_rvalid produces no write.

Verification
REQ-035 ixu1 valid rd=5 result 0xA, ixu2 valid rd=6 result 0xB -> next cycle rd 5/6, data 0xA/0xB, rf_we=3'b011.
REQ-036 Load rd=7; mem_rvalid with 0xDEADBEEF three cycles later:
- stall=1 for exactly three cycles.
- Then lsu_wb_rd=7, data=0xDEADBEEF, is_load=1, rf_we=3'b100.
REQ-037 ixu1 rd=9 result 1, ixu2 rd=9 result 2 -> ixu1 lane writes 1; ixu2 lane rd=0, data=0; rf_we=3'b001.
REQ-038 Load with TIMEOUT=4 and no mem_rvalid -> load_timeout=1 after 4 WAIT_MEM cycles, state IDLE, no LSU write; a later mem_rvalid is ignored.
REQ-039 rd=0 on all valid lanes -> all wb outputs 0, rf_we=0.
REQ-040 rst_n=0 mid-WAIT_MEM -> stall=0 next cycle; following mem_rvalid produces rf_we=0.
